// File: rtl/screen_mem_arbiter.sv
// Screen memory arbiter: shares the single-port 8K x 16 screen RAM between the
// CPU data port (held req/ack) and the pipelined video scanout fetcher.
// Video has fixed priority. A starvation counter lets the CPU win after
// STARVE_LIMIT consecutive denied cycles.
// Optional feature macro: SCREEN_ARB_STATS_EN adds the conflict_count output.
module screen_mem_arbiter #(
  parameter int unsigned AW           = 13,
  parameter int unsigned DW           = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic          vid_valid,
  output logic [DW-1:0] vid_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
`ifdef SCREEN_ARB_STATS_EN
  ,
  output logic [15:0]   conflict_count
`endif
);

  localparam int unsigned SW = 4;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_VID  = 2'd2
  } tag_e;

  logic          cpu_elig_c;
  logic          cpu_gnt_c;
  logic          vid_gnt_c;
  logic          cpu_rd_ret_c;
  logic          vid_rd_ret_c;

  logic          cpu_busy_q, cpu_busy_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  tag_e          tag1_q, tag1_d;
  tag_e          tag2_q, tag2_d;
  logic          wr_ack_q, wr_ack_d;
  logic [DW-1:0] cpu_hold_q, cpu_hold_d;
  logic [DW-1:0] vid_hold_q, vid_hold_d;

  // Grant decision: video first unless the CPU has waited STARVE_LIMIT cycles
  always_comb begin
    cpu_elig_c = cpu_req & ~cpu_busy_q;
    cpu_gnt_c  = reset & cpu_elig_c &
                 (~vid_req | (starve_q == SW'(STARVE_LIMIT)));
    vid_gnt_c  = reset & vid_req & ~cpu_gnt_c;
  end

  // Read return routing: stage-2 tag marks which requester owns ram_rdata now
  always_comb begin
    cpu_rd_ret_c = (tag2_q == TAG_CPU);
    vid_rd_ret_c = (tag2_q == TAG_VID);
  end

  // Next-state logic for the RAM port, return pipeline, busy and starvation
  always_comb begin
    cpu_busy_d  = cpu_busy_q;
    starve_d    = starve_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    tag1_d      = TAG_NONE;
    tag2_d      = tag1_q;
    wr_ack_d    = 1'b0;
    cpu_hold_d  = cpu_hold_q;
    vid_hold_d  = vid_hold_q;

    if (cpu_gnt_c) begin
      ram_addr_d = cpu_addr;
      ram_we_d   = cpu_we;
      if (cpu_we) begin
        ram_wdata_d = cpu_wdata;
        wr_ack_d    = 1'b1;
      end else begin
        tag1_d = TAG_CPU;
      end
    end else if (vid_gnt_c) begin
      ram_addr_d = vid_addr;
      tag1_d     = TAG_VID;
    end

    // Busy spans from the grant edge to the edge that ends the ack cycle
    if (cpu_busy_q) begin
      if (cpu_ack) begin
        cpu_busy_d = 1'b0;
      end
    end else if (cpu_gnt_c) begin
      cpu_busy_d = 1'b1;
    end

    if (!cpu_elig_c || cpu_gnt_c) begin
      starve_d = '0;
    end else if (vid_gnt_c && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end

    if (cpu_rd_ret_c) begin
      cpu_hold_d = ram_rdata;
    end
    if (vid_rd_ret_c) begin
      vid_hold_d = ram_rdata;
    end
  end

  // State registers; reset drops every in-flight access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_busy_q  <= 1'b0;
      starve_q    <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      wr_ack_q    <= 1'b0;
      cpu_hold_q  <= '0;
      vid_hold_q  <= '0;
    end else begin
      cpu_busy_q  <= cpu_busy_d;
      starve_q    <= starve_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      wr_ack_q    <= wr_ack_d;
      cpu_hold_q  <= cpu_hold_d;
      vid_hold_q  <= vid_hold_d;
    end
  end

  // Output drive: read data passes straight through in its return cycle, then holds
  always_comb begin
    vid_gnt   = vid_gnt_c;
    ram_addr  = ram_addr_q;
    ram_we    = ram_we_q;
    ram_wdata = ram_wdata_q;
    cpu_ack   = wr_ack_q | cpu_rd_ret_c;
    vid_valid = vid_rd_ret_c;
    cpu_rdata = cpu_rd_ret_c ? ram_rdata : cpu_hold_q;
    vid_rdata = vid_rd_ret_c ? ram_rdata : vid_hold_q;
  end

`ifdef SCREEN_ARB_STATS_EN
  logic [CW-1:0] conf_q, conf_d;

  // Count cycles where an eligible CPU access lost arbitration, saturating
  always_comb begin
    conf_d = conf_q;
    if (cpu_elig_c && !cpu_gnt_c && (conf_q != {CW{1'b1}})) begin
      conf_d = conf_q + CW'(1);
    end
  end

  // Conflict counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conf_q <= '0;
    end else begin
      conf_q <= conf_d;
    end
  end

  assign conflict_count = conf_q;
`endif

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Bench for screen_mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model with a shadow memory.
module tb_screen_mem_arbiter;

  localparam int AW    = 13;
  localparam int DW    = 16;
  localparam int LIMIT = 4;
  localparam int NC    = 1500;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_gnt, vid_valid;
  logic [DW-1:0] vid_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
`ifdef SCREEN_ARB_STATS_EN
  logic [15:0]   conflict_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  bit            e_ack   [0:NC+3];
  bit            e_rd    [0:NC+3];
  logic [DW-1:0] e_cdata [0:NC+3];
  bit            e_vv    [0:NC+3];
  logic [DW-1:0] e_vdata [0:NC+3];
  bit            e_we    [0:NC+3];
  logic [AW-1:0] e_waddr [0:NC+3];
  logic [DW-1:0] e_wdata [0:NC+3];

  screen_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_gnt   (vid_gnt),
    .vid_valid (vid_valid),
    .vid_rdata (vid_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
`ifdef SCREEN_ARB_STATS_EN
    ,
    .conflict_count (conflict_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read single-port RAM (read returns the old word on a same-cycle write)
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    vid_req   = 1'b0;
    vid_addr  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    next_cycle();
    @(negedge clk);
    n_checks++; if (ram_addr !== '0)  begin n_fail++; $display("FAIL reset_ram_addr got %h exp 0", ram_addr); end
    n_checks++; if (ram_we !== 1'b0)  begin n_fail++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
    n_checks++; if (ram_wdata !== '0) begin n_fail++; $display("FAIL reset_ram_wdata got %h exp 0", ram_wdata); end
    n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ack got %b exp 0", cpu_ack); end
    n_checks++; if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vid_valid got %b exp 0", vid_valid); end
    n_checks++; if (cpu_rdata !== '0) begin n_fail++; $display("FAIL reset_cpu_rdata got %h exp 0", cpu_rdata); end
    n_checks++; if (vid_rdata !== '0) begin n_fail++; $display("FAIL reset_vid_rdata got %h exp 0", vid_rdata); end
    n_checks++; if (vid_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_vid_gnt got %b exp 0", vid_gnt); end
`ifdef SCREEN_ARB_STATS_EN
    n_checks++; if (conflict_count !== 16'h0) begin n_fail++; $display("FAIL reset_conflict got %h exp 0", conflict_count); end
`endif
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_cpu_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0005; cpu_wdata = 16'hBEEF;
    @(negedge clk);
    n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL wr_c0_ack got %b exp 0", cpu_ack); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL wr_c1_ram_we got %b exp 1", ram_we); end
    n_checks++; if (ram_addr !== 13'h0005) begin n_fail++; $display("FAIL wr_c1_ram_addr got %h exp 0005", ram_addr); end
    n_checks++; if (ram_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr_c1_ram_wdata got %h exp beef", ram_wdata); end
    n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL wr_c1_ack got %b exp 1", cpu_ack); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL wr_c2_ram_we got %b exp 0", ram_we); end
    n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL wr_c2_ack got %b exp 0", cpu_ack); end
    n_checks++; if (mem[13'h0005] !== 16'hBEEF) begin n_fail++; $display("FAIL wr_mem got %h exp beef", mem[13'h0005]); end
    next_cycle();
  endtask

  task automatic test_video_stream();
    logic [DW-1:0] vals [0:2];
    vals[0] = 16'h00A0; vals[1] = 16'h00A1; vals[2] = 16'h00A2;
    for (int i = 0; i < 3; i++) mem[13'h1FFD + i] = vals[i];
    for (int c = 0; c < 6; c++) begin
      vid_req  = (c < 3);
      vid_addr = (c < 3) ? 13'(13'h1FFD + c) : '0;
      @(negedge clk);
      n_checks++;
      if (vid_gnt !== (c < 3)) begin n_fail++; $display("FAIL vid_gnt_c%0d got %b exp %b", c, vid_gnt, (c < 3)); end
      n_checks++;
      if (vid_valid !== (c >= 2 && c <= 4)) begin n_fail++; $display("FAIL vid_valid_c%0d got %b exp %b", c, vid_valid, (c >= 2 && c <= 4)); end
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (vid_rdata !== vals[c-2]) begin n_fail++; $display("FAIL vid_rdata_c%0d got %h exp %h", c, vid_rdata, vals[c-2]); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_starvation();
    do_reset();
    mem[13'h0010] = 16'h1234;
    for (int c = 0; c < 9; c++) begin
      vid_req  = 1'b1;
      vid_addr = 13'(13'h0200 + c);
      cpu_req  = (c <= 6);
      cpu_we   = 1'b0;
      cpu_addr = 13'h0010;
      @(negedge clk);
      n_checks++;
      if (vid_gnt !== (c != 4)) begin n_fail++; $display("FAIL starve_vid_gnt_c%0d got %b exp %b", c, vid_gnt, (c != 4)); end
      n_checks++;
      if (cpu_ack !== (c == 6)) begin n_fail++; $display("FAIL starve_cpu_ack_c%0d got %b exp %b", c, cpu_ack, (c == 6)); end
      if (c == 6) begin
        n_checks++;
        if (cpu_rdata !== 16'h1234) begin n_fail++; $display("FAIL starve_cpu_rdata got %h exp 1234", cpu_rdata); end
      end
`ifdef SCREEN_ARB_STATS_EN
      if (c >= 5) begin
        n_checks++;
        if (conflict_count !== 16'd4) begin n_fail++; $display("FAIL starve_conflict_c%0d got %0d exp 4", c, conflict_count); end
      end
`endif
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_midop();
    vid_req = 1'b1; vid_addr = 13'h0ABC;
    @(negedge clk);
    n_checks++; if (vid_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_mid_gnt got %b exp 1", vid_gnt); end
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    for (int c = 1; c < 6; c++) begin
      if (c == 3) reset = 1'b1;
      @(negedge clk);
      n_checks++; if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid_c%0d got %b exp 0", c, vid_valid); end
      n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack_c%0d got %b exp 0", c, cpu_ack); end
      n_checks++; if (ram_addr !== '0) begin n_fail++; $display("FAIL rst_mid_addr_c%0d got %h exp 0", c, ram_addr); end
      n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_we_c%0d got %b exp 0", c, ram_we); end
      n_checks++; if (vid_rdata !== '0) begin n_fail++; $display("FAIL rst_mid_vrdata_c%0d got %h exp 0", c, vid_rdata); end
      n_checks++; if (cpu_rdata !== '0) begin n_fail++; $display("FAIL rst_mid_crdata_c%0d got %h exp 0", c, cpu_rdata); end
      next_cycle();
    end
  endtask

  task automatic test_write_read_order();
    mem[13'h0100] = 16'h0000;
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c <= 1) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0100; cpu_wdata = 16'h5555;
      end else if (c <= 4) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100;
      end
      if (c == 1) begin vid_req = 1'b1; vid_addr = 13'h0100; end
      @(negedge clk);
      if (c == 1) begin
        n_checks++; if (vid_gnt !== 1'b1) begin n_fail++; $display("FAIL wro_vid_gnt got %b exp 1", vid_gnt); end
      end
      n_checks++;
      if (cpu_ack !== (c == 1 || c == 4)) begin n_fail++; $display("FAIL wro_ack_c%0d got %b exp %b", c, cpu_ack, (c == 1 || c == 4)); end
      n_checks++;
      if (vid_valid !== (c == 3)) begin n_fail++; $display("FAIL wro_vvalid_c%0d got %b exp %b", c, vid_valid, (c == 3)); end
      if (c == 3) begin
        n_checks++; if (vid_rdata !== 16'h5555) begin n_fail++; $display("FAIL wro_vid_rdata got %h exp 5555", vid_rdata); end
      end
      if (c == 4) begin
        n_checks++; if (cpu_rdata !== 16'h5555) begin n_fail++; $display("FAIL wro_cpu_rdata got %h exp 5555", cpu_rdata); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int  starve;
    int  busy_until;
    bit  pend;
    bit  elig, cwin, vwin;
    int  e_conf;
    do_reset();
    for (int a = 0; a < (1 << AW); a++) shadow[a] = mem[a];
    starve = 0; busy_until = -1; pend = 1'b0; e_conf = 0;
    for (int c = 0; c < NC; c++) begin
      if (!pend && ($urandom_range(0, 2) == 0)) begin
        pend      = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 13'($urandom_range(0, 15));
        cpu_wdata = 16'($urandom);
      end
      cpu_req  = pend;
      vid_req  = ($urandom_range(0, 3) != 0);
      vid_addr = 13'($urandom_range(0, 15));
      @(negedge clk);
      elig = pend && (c > busy_until);
      cwin = elig && (!vid_req || starve == LIMIT);
      vwin = vid_req && !cwin;
      if (cwin) begin
        if (cpu_we) begin
          shadow[cpu_addr] = cpu_wdata;
          e_ack[c+1] = 1'b1; e_we[c+1] = 1'b1;
          e_waddr[c+1] = cpu_addr; e_wdata[c+1] = cpu_wdata;
          busy_until = c + 1;
        end else begin
          e_ack[c+2] = 1'b1; e_rd[c+2] = 1'b1; e_cdata[c+2] = shadow[cpu_addr];
          busy_until = c + 2;
        end
      end else if (vwin) begin
        e_vv[c+2] = 1'b1; e_vdata[c+2] = shadow[vid_addr];
      end
      n_checks++;
      if (vid_gnt !== vwin) begin n_fail++; $display("FAIL rnd_vid_gnt cyc %0d got %b exp %b", c, vid_gnt, vwin); end
      n_checks++;
      if (cpu_ack !== e_ack[c]) begin n_fail++; $display("FAIL rnd_cpu_ack cyc %0d got %b exp %b", c, cpu_ack, e_ack[c]); end
      if (e_rd[c]) begin
        n_checks++;
        if (cpu_rdata !== e_cdata[c]) begin n_fail++; $display("FAIL rnd_cpu_rdata cyc %0d got %h exp %h", c, cpu_rdata, e_cdata[c]); end
      end
      n_checks++;
      if (vid_valid !== e_vv[c]) begin n_fail++; $display("FAIL rnd_vid_valid cyc %0d got %b exp %b", c, vid_valid, e_vv[c]); end
      if (e_vv[c]) begin
        n_checks++;
        if (vid_rdata !== e_vdata[c]) begin n_fail++; $display("FAIL rnd_vid_rdata cyc %0d got %h exp %h", c, vid_rdata, e_vdata[c]); end
      end
      n_checks++;
      if (ram_we !== e_we[c]) begin n_fail++; $display("FAIL rnd_ram_we cyc %0d got %b exp %b", c, ram_we, e_we[c]); end
      if (e_we[c]) begin
        n_checks++;
        if (ram_addr !== e_waddr[c] || ram_wdata !== e_wdata[c]) begin
          n_fail++; $display("FAIL rnd_ram_write cyc %0d got %h/%h exp %h/%h", c, ram_addr, ram_wdata, e_waddr[c], e_wdata[c]);
        end
      end
`ifdef SCREEN_ARB_STATS_EN
      n_checks++;
      if (conflict_count !== 16'(e_conf)) begin n_fail++; $display("FAIL rnd_conflict cyc %0d got %0d exp %0d", c, conflict_count, e_conf); end
`endif
      if (elig && !cwin && e_conf < 16'hFFFF) e_conf++;
      if (!elig || cwin) starve = 0;
      else if (starve < LIMIT) starve++;
      if (e_ack[c]) pend = 1'b0;
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = 16'($urandom);
    idle_inputs();
    reset = 1'b0;
    #1;
    test_reset();
    test_cpu_write();
    test_video_stream();
    test_starvation();
    test_reset_midop();
    test_write_read_order();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
